// File: rtl/axi_txn_scoreboard_mc.sv
// Multi-channel in-order transaction scoreboard.
// Each channel buffers expected and actual records in separate FIFOs. A
// round-robin arbiter picks one channel per cycle whose two heads are both
// present, pops them and registers the masked compare result.
module axi_txn_scoreboard_mc #(
  parameter int                N_CH         = 2,
  parameter int                REC_W        = 64,
  parameter int                DEPTH        = 4,
  parameter logic [REC_W-1:0]  CMP_MASK     = '1,
  parameter int                BACKPRESSURE = 1,
  parameter int                TMO_CYC      = 1024,
  parameter int                CNT_W        = 16,
  localparam int               CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [N_CH-1:0]        exp_valid,
  output logic [N_CH-1:0]        exp_ready,
  input  logic [N_CH*REC_W-1:0]  exp_rec,
  input  logic [N_CH-1:0]        act_valid,
  output logic [N_CH-1:0]        act_ready,
  input  logic [N_CH*REC_W-1:0]  act_rec,
  input  logic                   clr,
  output logic                   cmp_done,
  output logic                   cmp_pass,
  output logic [CH_W-1:0]        cmp_ch,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [N_CH-1:0]        ovf_err,
  output logic [N_CH-1:0]        tmo_err,
  output logic                   idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CHX_W = CH_W + 1;
  localparam int TMO_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CHX_W-1:0] NCH_X = CHX_W'(N_CH);

  logic [REC_W-1:0] exp_mem [N_CH][DEPTH];
  logic [REC_W-1:0] act_mem [N_CH][DEPTH];
  logic [PTR_W:0]   exp_wr [N_CH];
  logic [PTR_W:0]   exp_rd [N_CH];
  logic [PTR_W:0]   act_wr [N_CH];
  logic [PTR_W:0]   act_rd [N_CH];
  logic [TMO_W-1:0] tmo_cnt [N_CH];

  logic [N_CH-1:0] exp_empty, exp_full, act_empty, act_full;
  logic [N_CH-1:0] exp_push, act_push, exp_drop, act_drop;
  logic [N_CH-1:0] elig, pop;
  logic [CH_W-1:0] rr_ptr, gnt_ch;
  logic [CHX_W-1:0] idx_x;
  logic            gnt_vld;
  logic [REC_W-1:0] exp_head, act_head;
  logic            cmp_ok;

  logic            vld_p1, pass_p1;
  logic [CH_W-1:0] ch_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // FIFO status flags; the extra pointer bit separates full from empty
  always_comb begin
    exp_empty = '0;
    exp_full  = '0;
    act_empty = '0;
    act_full  = '0;
    for (int c = 0; c < N_CH; c++) begin
      exp_empty[c] = (exp_wr[c] == exp_rd[c]);
      act_empty[c] = (act_wr[c] == act_rd[c]);
      exp_full[c]  = ((exp_wr[c] ^ exp_rd[c]) == {1'b1, {PTR_W{1'b0}}});
      act_full[c]  = ((act_wr[c] ^ act_rd[c]) == {1'b1, {PTR_W{1'b0}}});
    end
    elig = ~exp_empty & ~act_empty;
    idle = (&exp_empty) & (&act_empty);
  end

  // Round-robin search starting at rr_ptr; first eligible channel wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx_x   = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx_x = {1'b0, rr_ptr} + CHX_W'(i);
      if (idx_x >= NCH_X) idx_x = idx_x - NCH_X;
      if (!gnt_vld && elig[idx_x[CH_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_ch  = idx_x[CH_W-1:0];
      end
    end
    pop = '0;
    if (gnt_vld) pop[gnt_ch] = 1'b1;
  end

  // Ready follows the FIFO state only; a same-cycle pop frees a full slot
  always_comb begin
    if (BACKPRESSURE != 0) begin
      exp_ready = ~exp_full | pop;
      act_ready = ~act_full | pop;
    end else begin
      exp_ready = '1;
      act_ready = '1;
    end
    exp_push = exp_valid & exp_ready & (~exp_full | pop);
    act_push = act_valid & act_ready & (~act_full | pop);
    exp_drop = exp_valid & exp_ready & exp_full & ~pop;
    act_drop = act_valid & act_ready & act_full & ~pop;
  end

  // Masked compare of the granted channel's two heads
  always_comb begin
    exp_head = exp_mem[gnt_ch][exp_rd[gnt_ch][PTR_W-1:0]];
    act_head = act_mem[gnt_ch][act_rd[gnt_ch][PTR_W-1:0]];
    cmp_ok   = (((exp_head ^ act_head) & CMP_MASK) == '0);
  end

  // Record storage; payload needs no reset since pointers gate visibility
  always_ff @(posedge aclk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (exp_push[c]) exp_mem[c][exp_wr[c][PTR_W-1:0]] <= exp_rec[c*REC_W +: REC_W];
      if (act_push[c]) act_mem[c][act_wr[c][PTR_W-1:0]] <= act_rec[c*REC_W +: REC_W];
    end
  end

  // FIFO pointers advance on push and on grant
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < N_CH; c++) begin
        exp_wr[c] <= '0;
        exp_rd[c] <= '0;
        act_wr[c] <= '0;
        act_rd[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (exp_push[c]) exp_wr[c] <= exp_wr[c] + 1'b1;
        if (act_push[c]) act_wr[c] <= act_wr[c] + 1'b1;
        if (pop[c]) begin
          exp_rd[c] <= exp_rd[c] + 1'b1;
          act_rd[c] <= act_rd[c] + 1'b1;
        end
      end
    end
  end

  // ---- stage p1: registered compare result, arbiter pointer, counters ----
  // Result register and saturating counters; clr wins over a same-cycle result
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1   <= 1'b0;
      pass_p1  <= 1'b0;
      ch_p1    <= '0;
      rr_ptr   <= '0;
      pass_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      vld_p1 <= gnt_vld;
      if (gnt_vld) begin
        pass_p1 <= cmp_ok;
        ch_p1   <= gnt_ch;
        rr_ptr  <= (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
      end
      if (clr) begin
        pass_cnt <= '0;
        err_cnt  <= '0;
      end else if (gnt_vld) begin
        if (cmp_ok) pass_cnt <= sat_inc(pass_cnt);
        else        err_cnt  <= sat_inc(err_cnt);
      end
    end
  end

  assign cmp_done = vld_p1;
  assign cmp_pass = pass_p1;
  assign cmp_ch   = ch_p1;

  // Sticky overflow and per-channel starvation timers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ovf_err <= '0;
      tmo_err <= '0;
      for (int c = 0; c < N_CH; c++) tmo_cnt[c] <= '0;
    end else if (clr) begin
      ovf_err <= '0;
      tmo_err <= '0;
      for (int c = 0; c < N_CH; c++) tmo_cnt[c] <= '0;
    end else begin
      ovf_err <= ovf_err | exp_drop | act_drop;
      for (int c = 0; c < N_CH; c++) begin
        if ((exp_empty[c] && act_empty[c]) || pop[c]) begin
          tmo_cnt[c] <= '0;
        end else if (exp_empty[c] != act_empty[c]) begin
          if (TMO_CYC != 0 && tmo_cnt[c] != TMO_W'(TMO_CYC)) begin
            tmo_cnt[c] <= tmo_cnt[c] + 1'b1;
            if (tmo_cnt[c] == TMO_W'(TMO_CYC - 1)) tmo_err[c] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_txn_scoreboard_mc.sv
// Bench for axi_txn_scoreboard_mc: five instances with different parameter
// sets; stimulus queues expected compare results, a monitor checks pulses.
module tb_axi_txn_scoreboard_mc;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [1:0]  ev [5];
  logic [1:0]  av [5];
  logic [31:0] er [5];
  logic [31:0] ar [5];
  logic [4:0]  clr;
  logic [4:0]  cdone, cpass, cch, idl;
  logic [1:0]  erdy [5];
  logic [1:0]  ardy [5];
  logic [1:0]  ovf [5];
  logic [1:0]  tmo [5];
  logic [15:0] pcnt [5];
  logic [15:0] ecnt [5];

  // 0: base  1: mask bit0 off  2: no backpressure  3: timeout 8  4: 2-bit counters
  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int          BP  = (g == 2) ? 0 : 1;
    localparam int          TMO = (g == 3) ? 8 : 0;
    localparam int          CW  = (g == 4) ? 2 : 16;
    localparam logic [15:0] MSK = (g == 1) ? 16'hFFFE : 16'hFFFF;
    logic [CW-1:0] pc, ec;
    logic [1:0]    rdy_e, rdy_a, ov_w, tm_w;
    logic          cd_w, cp_w, cc_w, id_w;
    axi_txn_scoreboard_mc #(
      .N_CH(2), .REC_W(16), .DEPTH(4), .CMP_MASK(MSK),
      .BACKPRESSURE(BP), .TMO_CYC(TMO), .CNT_W(CW)
    ) u_dut (
      .aclk(clk), .aresetn(aresetn),
      .exp_valid(ev[g]), .exp_ready(rdy_e), .exp_rec(er[g]),
      .act_valid(av[g]), .act_ready(rdy_a), .act_rec(ar[g]),
      .clr(clr[g]),
      .cmp_done(cd_w), .cmp_pass(cp_w), .cmp_ch(cc_w),
      .pass_cnt(pc), .err_cnt(ec),
      .ovf_err(ov_w), .tmo_err(tm_w), .idle(id_w)
    );
    assign cdone[g] = cd_w;
    assign cpass[g] = cp_w;
    assign cch[g]   = cc_w;
    assign idl[g]   = id_w;
    assign erdy[g]  = rdy_e;
    assign ardy[g]  = rdy_a;
    assign ovf[g]   = ov_w;
    assign tmo[g]   = tm_w;
    assign pcnt[g]  = 16'(pc);
    assign ecnt[g]  = 16'(ec);
  end

  typedef struct packed {
    logic [2:0] d;
    logic       p;
    logic       ch;
  } sb_t;
  sb_t sbq [$];

  int n_chk = 0;
  int n_pass = 0;
  int run0 = 0;
  int maxrun0 = 0;

  task automatic chk(string nm, longint got, longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(int d, int side, int ch, logic [15:0] rec);
    if (side == 0) begin
      ev[d][ch] = 1'b1;
      er[d][ch*16 +: 16] = rec;
    end else begin
      av[d][ch] = 1'b1;
      ar[d][ch*16 +: 16] = rec;
    end
  endtask

  task automatic drop_all(int d);
    ev[d] = '0;
    av[d] = '0;
  endtask

  task automatic expect_cmp(int d, int ch, bit p);
    sb_t e;
    e.d  = 3'(d);
    e.p  = p;
    e.ch = 1'(ch);
    sbq.push_back(e);
  endtask

  task automatic push1(int d, int side, int ch, logic [15:0] rec);
    lane(d, side, ch, rec);
    cyc();
    drop_all(d);
  endtask

  task automatic pair(int d, int ch, logic [15:0] e, logic [15:0] a, bit p);
    expect_cmp(d, ch, p);
    lane(d, 0, ch, e);
    lane(d, 1, ch, a);
    cyc();
    drop_all(d);
  endtask

  // Wait (bounded) until the instance is drained and all results are seen
  task automatic settle(int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (idl[d] && sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk("settle", ok, 1);
    repeat (2) cyc();
  endtask

  // Monitor: every cmp_done pops the oldest expectation and compares it
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 5; d++) begin
        if (cdone[d]) begin
          if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_cmp_done: dut%0d pulsed, want no pulse", d);
          end else begin
            e = sbq.pop_front();
            chk("cmp_dut", d, e.d);
            chk("cmp_pass", cpass[d], e.p);
            chk("cmp_ch", cch[d], e.ch);
          end
        end
      end
      if (cdone[0]) begin
        run0++;
        if (run0 > maxrun0) maxrun0 = run0;
      end else begin
        run0 = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    aresetn = 1'b0;
    clr = '0;
    for (int d = 0; d < 5; d++) begin
      ev[d] = '0; av[d] = '0; er[d] = '0; ar[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_idle", idl[0], 1);
    chk("rst_cmp_done", cdone[0], 0);
    chk("rst_cmp_pass", cpass[0], 0);
    chk("rst_pass_cnt", pcnt[0], 0);
    chk("rst_err_cnt", ecnt[0], 0);
    chk("rst_exp_ready", erdy[0], 3);
    chk("rst_act_ready", ardy[0], 3);
    chk("rst_exp_ready_nobp", erdy[2], 3);
    chk("rst_ovf", ovf[2], 0);
    chk("rst_tmo", tmo[3], 0);
    aresetn = 1'b1;
    cyc();

    // ch0 match with minimum latency
    push1(0, 0, 0, 16'h1111);
    chk("idle_after_push", idl[0], 0);
    expect_cmp(0, 0, 1);
    push1(0, 1, 0, 16'h1111);
    chk("latency_grant_cycle", cdone[0], 0);
    cyc();
    chk("latency_done_cycle", cdone[0], 1);
    settle(0);
    chk("t1_pass_cnt", pcnt[0], 1);
    chk("t1_idle", idl[0], 1);

    // ch1 mismatch in bit0, full mask
    push1(0, 0, 1, 16'hAAAA);
    expect_cmp(0, 1, 0);
    push1(0, 1, 1, 16'hAAAB);
    settle(0);
    chk("t2_err_cnt", ecnt[0], 1);
    chk("t2_pass_cnt", pcnt[0], 1);

    // same records with bit0 masked off
    push1(1, 0, 1, 16'hAAAA);
    expect_cmp(1, 1, 1);
    push1(1, 1, 1, 16'hAAAB);
    settle(1);
    chk("t3_mask_pass_cnt", pcnt[1], 1);
    chk("t3_mask_err_cnt", ecnt[1], 0);

    // clr zeroes counters
    clr[0] = 1'b1;
    cyc();
    clr[0] = 1'b0;
    chk("clr_pass_cnt", pcnt[0], 0);
    chk("clr_err_cnt", ecnt[0], 0);

    // both channels busy: alternating grants, 8 back-to-back results
    maxrun0 = 0;
    for (int i = 0; i < 4; i++) begin
      expect_cmp(0, 0, 1);
      expect_cmp(0, 1, 1);
    end
    for (int i = 0; i < 4; i++) begin
      lane(0, 0, 0, 16'h0400 + 16'(i));
      lane(0, 1, 0, 16'h0400 + 16'(i));
      lane(0, 0, 1, 16'h0410 + 16'(i));
      lane(0, 1, 1, 16'h0410 + 16'(i));
      cyc();
      drop_all(0);
    end
    settle(0);
    chk("rr_pass_cnt", pcnt[0], 8);
    chk("rr_consecutive", maxrun0, 8);

    // backpressure: 5th exp record held, not lost
    for (int k = 0; k < 4; k++) push1(0, 0, 0, 16'h5000 + 16'(k));
    chk("bp_ready_full", erdy[0][0], 0);
    chk("bp_ready_other_ch", erdy[0][1], 1);
    lane(0, 0, 0, 16'h5004);
    repeat (3) cyc();
    chk("bp_ready_held", erdy[0][0], 0);
    for (int k = 0; k < 5; k++) begin
      expect_cmp(0, 0, 1);
      lane(0, 1, 0, 16'h5000 + 16'(k));
      acc = ev[0][0] & erdy[0][0];
      cyc();
      av[0] = '0;
      if (acc) ev[0][0] = 1'b0;
    end
    chk("bp_5th_accepted", ev[0][0], 0);
    ev[0] = '0;
    settle(0);
    chk("bp_pass_cnt", pcnt[0], 13);

    // no backpressure: 5th push dropped and flagged
    for (int k = 0; k < 5; k++) begin
      push1(2, 0, 0, 16'h6000 + 16'(k));
      if (k == 3) chk("nobp_ovf_before", ovf[2], 0);
    end
    chk("nobp_ovf", ovf[2], 1);
    chk("nobp_ready", erdy[2], 3);
    for (int k = 0; k < 4; k++) begin
      expect_cmp(2, 0, 1);
      push1(2, 1, 0, 16'h6000 + 16'(k));
    end
    settle(2);
    chk("nobp_pass_cnt", pcnt[2], 4);
    chk("nobp_ovf_sticky", ovf[2], 1);

    // starvation timeout of 8 cycles on ch1
    push1(3, 0, 1, 16'h3333);
    repeat (7) cyc();
    chk("tmo_before", tmo[3], 0);
    cyc();
    chk("tmo_at_8", tmo[3], 2);
    expect_cmp(3, 1, 1);
    push1(3, 1, 1, 16'h3333);
    settle(3);
    chk("tmo_pass_cnt", pcnt[3], 1);
    chk("tmo_sticky", tmo[3], 2);
    clr[3] = 1'b1;
    cyc();
    clr[3] = 1'b0;
    chk("tmo_clr", tmo[3], 0);
    chk("tmo_clr_cnt", pcnt[3], 0);

    // 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) pair(4, 0, 16'h4440 + 16'(k), 16'h4440 + 16'(k), 1'b1);
    settle(4);
    chk("sat_pass_cnt", pcnt[4], 3);

    // clr in the grant cycle of a failing compare
    push1(0, 0, 0, 16'h7777);
    expect_cmp(0, 0, 0);
    push1(0, 1, 0, 16'h7778);
    clr[0] = 1'b1;
    cyc();
    clr[0] = 1'b0;
    chk("clr_prio_err_cnt", ecnt[0], 0);
    settle(0);
    chk("clr_prio_err_cnt_after", ecnt[0], 0);

    // asynchronous reset with records buffered and a compare in flight
    pair(0, 0, 16'h8888, 16'h8888, 1'b1);
    settle(0);
    chk("pre_rst_pass_cnt", pcnt[0], 1);
    push1(0, 0, 0, 16'h9000);
    push1(0, 0, 0, 16'h9001);
    lane(0, 0, 0, 16'h9002);
    lane(0, 0, 1, 16'h9100);
    lane(0, 1, 1, 16'h9100);
    cyc();
    drop_all(0);
    chk("pre_rst_idle", idl[0], 0);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_idle", idl[0], 1);
    chk("mid_rst_cmp_done", cdone[0], 0);
    chk("mid_rst_pass_cnt", pcnt[0], 0);
    chk("mid_rst_err_cnt", ecnt[0], 0);
    repeat (2) cyc();
    aresetn = 1'b1;
    repeat (6) cyc();
    chk("post_rst_idle", idl[0], 1);
    chk("post_rst_ready", erdy[0], 3);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
